// File: rtl/irq_stim_gen_pkg.sv
// Shared definitions for the interrupt stimulus generator: config select codes,
// ctrl word bit positions and the per-channel mode encoding.
package irq_stim_gen_pkg;

  // cfg_sel codes
  localparam logic [1:0] CFG_SEL_PERIOD = 2'd0;
  localparam logic [1:0] CFG_SEL_OFFSET = 2'd1;
  localparam logic [1:0] CFG_SEL_WIDTH  = 2'd2;
  localparam logic [1:0] CFG_SEL_CTRL   = 2'd3;

  // Bit positions inside a ctrl write
  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_CLR  = 2;

  // Channel operating mode
  typedef enum logic {
    MODE_PULSE = 1'b0,
    MODE_LEVEL = 1'b1
  } mode_e;

  // Channel-select width; a single channel still gets a 1-bit select
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_stim_chan.sv
// One IRQ stimulus channel: config registers, phase counter, pulse-width counter,
// IRQ output and sticky overrun flag. Outputs are registered (one edge after the
// hit sample); there is no backpressure, ack only matters in LEVEL mode.
module irq_stim_chan
  import irq_stim_gen_pkg::*;
#(
  parameter int   CNT_W      = 16,
  parameter int   DEF_PERIOD = 20,
  parameter int   DEF_OFFSET = 1,
  parameter int   DEF_WIDTH  = 2,
  parameter logic DEF_EN     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [1:0]       sel_i,
  input  logic [CNT_W-1:0] wdata_i,
  input  logic             ack_i,
  output logic             irq_o,
  output logic             overrun_o
);

  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] RST_OFFSET = CNT_W'(DEF_OFFSET);
  localparam logic [CNT_W-1:0] RST_WIDTH  = CNT_W'(DEF_WIDTH);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] offset_q, offset_d;
  logic [CNT_W-1:0] width_q,  width_d;
  logic             en_q,     en_d;
  mode_e            mode_q,   mode_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] wcnt_q,   wcnt_d;
  logic             irq_q,    irq_d;
  logic             ovr_q,    ovr_d;
  logic             hit;
  logic             ovr_set;

  // Hit uses the pre-edge count; an offset beyond the period simply never matches
  assign hit = en_q && (cnt_q == offset_q);

  // Next-state: free-running counter and mode-specific IRQ, then config writes override
  always_comb begin
    period_d = period_q;
    offset_d = offset_q;
    width_d  = width_q;
    en_d     = en_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    wcnt_d   = wcnt_q;
    irq_d    = irq_q;
    ovr_d    = ovr_q;
    ovr_set  = 1'b0;

    // >= rather than == so a period shrunk below the live count wraps on the next edge;
    // period 0 makes period-1 all ones, giving the natural 2**CNT_W wrap
    if (en_q) begin
      cnt_d = (cnt_q >= period_q - ONE) ? '0 : cnt_q + ONE;
    end else begin
      cnt_d = '0;
    end

    if (mode_q == MODE_PULSE) begin
      // A hit during an active pulse reloads the width counter (retrigger)
      if (hit && (width_q != '0)) begin
        irq_d  = 1'b1;
        wcnt_d = width_q - ONE;
      end else if (wcnt_q != '0) begin
        irq_d  = 1'b1;
        wcnt_d = wcnt_q - ONE;
      end else begin
        irq_d  = 1'b0;
      end
    end else begin
      // Hit beats a simultaneous ack; an un-acked repeat hit is an overrun
      if (hit) begin
        irq_d   = 1'b1;
        ovr_set = irq_q & ~ack_i;
      end else if (ack_i) begin
        irq_d   = 1'b0;
      end
    end

    if (we_i) begin
      case (sel_i)
        CFG_SEL_PERIOD: period_d = wdata_i;
        CFG_SEL_OFFSET: offset_d = wdata_i;
        CFG_SEL_WIDTH:  width_d  = wdata_i;
        CFG_SEL_CTRL: begin
          en_d   = wdata_i[CTRL_EN];
          mode_d = wdata_i[CTRL_MODE] ? MODE_LEVEL : MODE_PULSE;
          // Disabling drops any activity but keeps the sticky overrun
          if (!en_d) begin
            cnt_d  = '0;
            wcnt_d = '0;
            irq_d  = 1'b0;
          end
          if (mode_d != mode_q) begin
            wcnt_d = '0;
            irq_d  = 1'b0;
          end
          if (wdata_i[CTRL_CLR]) begin
            ovr_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    // An overrun landing on the clear cycle still sets the flag
    if (ovr_set) begin
      ovr_d = 1'b1;
    end
  end

  // State register with asynchronous reset to the parameter defaults
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_q <= RST_PERIOD;
      offset_q <= RST_OFFSET;
      width_q  <= RST_WIDTH;
      en_q     <= DEF_EN;
      mode_q   <= MODE_PULSE;
      cnt_q    <= '0;
      wcnt_q   <= '0;
      irq_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      period_q <= period_d;
      offset_q <= offset_d;
      width_q  <= width_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      wcnt_q   <= wcnt_d;
      irq_q    <= irq_d;
      ovr_q    <= ovr_d;
    end
  end

  assign irq_o     = irq_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/irq_stim_gen.sv
// Multi-channel periodic interrupt stimulus generator with a simple config write port.
// irq_o/overrun_o are registered per channel; irq_any_o is their OR with no extra delay.
// No backpressure: one config write per cycle, out-of-range channel writes are dropped.
module irq_stim_gen
  import irq_stim_gen_pkg::*;
#(
  parameter int                 NUM_CH     = 4,
  parameter int                 CNT_W      = 16,
  parameter int                 DEF_PERIOD = 20,
  parameter int                 DEF_OFFSET = 1,
  parameter int                 DEF_WIDTH  = 2,
  parameter logic [NUM_CH-1:0]  DEF_EN     = '0,
  localparam int                CH_W       = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_sel,
  input  logic [CNT_W-1:0]  cfg_wdata,
  input  logic [NUM_CH-1:0] ack_i,
  output logic [NUM_CH-1:0] irq_o,
  output logic              irq_any_o,
  output logic [NUM_CH-1:0] overrun_o
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic we_ch;

    // Only the addressed channel sees the write strobe
    assign we_ch = cfg_we && (cfg_ch == CH_W'(i));

    irq_stim_chan #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_OFFSET (DEF_OFFSET),
      .DEF_WIDTH  (DEF_WIDTH),
      .DEF_EN     (DEF_EN[i])
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .we_i      (we_ch),
      .sel_i     (cfg_sel),
      .wdata_i   (cfg_wdata),
      .ack_i     (ack_i[i]),
      .irq_o     (irq_o[i]),
      .overrun_o (overrun_o[i])
    );
  end

  assign irq_any_o = |irq_o;

endmodule

// File: tb/tb_irq_stim_gen.sv
// Self-checking bench for irq_stim_gen: directed table vectors, hand-written
// multi-cycle corner sequences and a randomized run against a behavioural model.
module tb_irq_stim_gen;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [1:0]        cfg_sel;
  logic [CNT_W-1:0]  cfg_wdata;
  logic [NUM_CH-1:0] ack_i;
  logic [NUM_CH-1:0] irq_o;
  logic              irq_any_o;
  logic [NUM_CH-1:0] overrun_o;

  int n_tests = 0;
  int n_fail  = 0;

  irq_stim_gen #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .DEF_PERIOD (20),
    .DEF_OFFSET (1),
    .DEF_WIDTH  (2),
    .DEF_EN     (4'b0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_sel   (cfg_sel),
    .cfg_wdata (cfg_wdata),
    .ack_i     (ack_i),
    .irq_o     (irq_o),
    .irq_any_o (irq_any_o),
    .overrun_o (overrun_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- behavioural reference model ----------------
  // Pulse tracked as "cycles of high remaining", LEVEL as a latched bit.
  int m_per [NUM_CH];
  int m_off [NUM_CH];
  int m_wid [NUM_CH];
  int m_cnt [NUM_CH];
  int m_left[NUM_CH];
  bit m_en  [NUM_CH];
  bit m_lvl [NUM_CH];
  bit m_irq [NUM_CH];
  bit m_ovr [NUM_CH];

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_per[c] = 20; m_off[c] = 1; m_wid[c] = 2;
      m_cnt[c] = 0;  m_left[c] = 0;
      m_en[c] = 0; m_lvl[c] = 0; m_irq[c] = 0; m_ovr[c] = 0;
    end
  endfunction

  function automatic void model_step(input bit we, input int ch, input int sel,
                                     input int wd, input logic [NUM_CH-1:0] ack);
    for (int c = 0; c < NUM_CH; c++) begin
      bit hit;
      bit set;
      int per;
      hit = m_en[c] && (m_cnt[c] == m_off[c]);
      per = (m_per[c] == 0) ? 65536 : m_per[c];
      set = 0;
      if (!m_lvl[c]) begin
        if (hit && m_wid[c] != 0) m_left[c] = m_wid[c];
        else if (m_left[c] > 0)   m_left[c] = m_left[c] - 1;
        m_irq[c] = (m_left[c] > 0);
      end else begin
        if (hit) begin
          if (m_irq[c] && !ack[c]) set = 1;
          m_irq[c] = 1;
        end else if (ack[c]) begin
          m_irq[c] = 0;
        end
      end
      m_cnt[c] = m_en[c] ? ((m_cnt[c] >= per - 1) ? 0 : m_cnt[c] + 1) : 0;
      if (we && ch == c) begin
        case (sel)
          0: m_per[c] = wd;
          1: m_off[c] = wd;
          2: m_wid[c] = wd;
          default: begin
            bit ne;
            bit nm;
            ne = wd[0];
            nm = wd[1];
            if (!ne) begin m_cnt[c] = 0; m_left[c] = 0; m_irq[c] = 0; end
            if (nm != m_lvl[c]) begin m_left[c] = 0; m_irq[c] = 0; end
            if (wd[2]) m_ovr[c] = 0;
            m_en[c] = ne;
            m_lvl[c] = nm;
          end
        endcase
      end
      if (set) m_ovr[c] = 1;
    end
  endfunction

  function automatic logic [NUM_CH-1:0] m_irq_vec();
    logic [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_irq[c];
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] m_ovr_vec();
    logic [NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_ovr[c];
    return v;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge
  task automatic tick(input logic we, input logic [1:0] ch, input logic [1:0] sel,
                      input logic [CNT_W-1:0] wd, input logic [NUM_CH-1:0] ack);
    cfg_we = we; cfg_ch = ch; cfg_sel = sel; cfg_wdata = wd; ack_i = ack;
    model_step(we, int'(ch), int'(sel), int'(wd), ack);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 2'd0, 2'd0, '0, '0);
  endtask

  typedef struct {
    logic              we;
    logic [1:0]        ch;
    logic [1:0]        sel;
    logic [CNT_W-1:0]  wdata;
    logic [NUM_CH-1:0] ack;
    int                n;
    logic [NUM_CH-1:0] exp_irq;
    logic [NUM_CH-1:0] exp_ovr;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] ch, input logic [1:0] sel,
                              input logic [CNT_W-1:0] wd, input logic [NUM_CH-1:0] ack,
                              input int n, input logic [NUM_CH-1:0] ei,
                              input logic [NUM_CH-1:0] eo);
    vec_t v;
    v.we = we; v.ch = ch; v.sel = sel; v.wdata = wd; v.ack = ack;
    v.n = n; v.exp_irq = ei; v.exp_ovr = eo;
    return v;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs[$];
    bit   found;
    bit   exp1;

    rst = 1'b1; cfg_we = 0; cfg_ch = 0; cfg_sel = 0; cfg_wdata = '0; ack_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_irq", irq_o, 0);
    check("reset_any", irq_any_o, 0);
    check("reset_ovr", overrun_o, 0);

    // 1: defaults, enable ch0 -> 2-cycle pulse every 20, first rise 2 edges after write
    tick(1'b1, 2'd0, 2'd3, 16'd1, '0);
    check("t1_k0", irq_o, 0);
    for (int k = 1; k <= 44; k++) begin
      idle();
      exp1 = (k >= 2) && (((k % 20) == 2) || ((k % 20) == 3));
      check($sformatf("t1_irq_k%0d", k), irq_o, {3'b000, exp1});
      check($sformatf("t1_any_k%0d", k), irq_any_o, exp1);
    end
    tick(1'b1, 2'd0, 2'd3, 16'd0, '0);
    check("t1_disable", irq_o, 0);

    // 2/3: LEVEL latch, overrun, ack, clear; then hit+ack on ch2
    vecs.push_back(mk(1, 2'd1, 2'd0, 16'd8, 4'h0, 1,  4'h0, 4'h0));
    vecs.push_back(mk(1, 2'd1, 2'd1, 16'd3, 4'h0, 1,  4'h0, 4'h0));
    vecs.push_back(mk(1, 2'd1, 2'd3, 16'd3, 4'h0, 1,  4'h0, 4'h0));
    vecs.push_back(mk(0, 2'd0, 2'd0, 16'd0, 4'h0, 3,  4'h0, 4'h0));
    vecs.push_back(mk(0, 2'd0, 2'd0, 16'd0, 4'h0, 1,  4'h2, 4'h0));
    vecs.push_back(mk(0, 2'd0, 2'd0, 16'd0, 4'h0, 7,  4'h2, 4'h0));
    vecs.push_back(mk(0, 2'd0, 2'd0, 16'd0, 4'h0, 1,  4'h2, 4'h2));
    vecs.push_back(mk(0, 2'd0, 2'd0, 16'd0, 4'h2, 1,  4'h0, 4'h2));
    vecs.push_back(mk(1, 2'd1, 2'd3, 16'd7, 4'h0, 1,  4'h0, 4'h0));
    vecs.push_back(mk(1, 2'd1, 2'd3, 16'd2, 4'h0, 1,  4'h0, 4'h0));
    vecs.push_back(mk(1, 2'd2, 2'd3, 16'd3, 4'h0, 1,  4'h0, 4'h0));
    vecs.push_back(mk(0, 2'd0, 2'd0, 16'd0, 4'h0, 1,  4'h0, 4'h0));
    vecs.push_back(mk(0, 2'd0, 2'd0, 16'd0, 4'h0, 1,  4'h4, 4'h0));
    vecs.push_back(mk(0, 2'd0, 2'd0, 16'd0, 4'h0, 19, 4'h4, 4'h0));
    vecs.push_back(mk(0, 2'd0, 2'd0, 16'd0, 4'h4, 1,  4'h4, 4'h0));
    vecs.push_back(mk(0, 2'd0, 2'd0, 16'd0, 4'h4, 1,  4'h0, 4'h0));
    vecs.push_back(mk(1, 2'd2, 2'd3, 16'd2, 4'h0, 1,  4'h0, 4'h0));
    for (int r = 0; r < vecs.size(); r++) begin
      repeat (vecs[r].n) tick(vecs[r].we, vecs[r].ch, vecs[r].sel, vecs[r].wdata, vecs[r].ack);
      check($sformatf("vec%0d_irq", r), irq_o, vecs[r].exp_irq);
      check($sformatf("vec%0d_ovr", r), overrun_o, vecs[r].exp_ovr);
    end

    // 4: ch3 period 10 shrunk to 4 while cnt=7 -> wrap next edge, then period 4
    tick(1'b1, 2'd3, 2'd0, 16'd10, '0);
    for (int k = 0; k <= 21; k++) begin
      if (k == 0)      tick(1'b1, 2'd3, 2'd3, 16'd1, '0);
      else if (k == 7) tick(1'b1, 2'd3, 2'd0, 16'd4, '0);
      else             idle();
      exp1 = (k == 2) || (k == 3) || ((k >= 10) && (((k - 10) % 4) < 2));
      check($sformatf("t4_k%0d", k), irq_o, {exp1, 3'b000});
    end
    tick(1'b1, 2'd3, 2'd3, 16'd0, '0);

    // 5: width 0 never asserts; width 25 > period 20 holds high
    tick(1'b1, 2'd0, 2'd2, 16'd0, '0);
    tick(1'b1, 2'd0, 2'd3, 16'd1, '0);
    for (int k = 0; k < 45; k++) begin
      idle();
      check($sformatf("t5_w0_k%0d", k), irq_o, 0);
    end
    tick(1'b1, 2'd0, 2'd2, 16'd25, '0);
    found = 0;
    for (int k = 0; k < 25 && !found; k++) begin
      idle();
      found = irq_o[0];
    end
    check("t5_rise", found, 1);
    for (int k = 0; k < 50; k++) begin
      idle();
      check($sformatf("t5_hold_k%0d", k), irq_o, 4'h1);
    end

    // 6: async reset mid-pulse and mid-LEVEL
    tick(1'b1, 2'd1, 2'd3, 16'd3, '0);
    repeat (5) idle();
    check("t6_pre", irq_o, 4'h3);
    cfg_we = 0; ack_i = '0;
    #2 rst = 1'b1;
    #1;
    check("t6_rst_irq", irq_o, 0);
    check("t6_rst_any", irq_any_o, 0);
    check("t6_rst_ovr", overrun_o, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    tick(1'b1, 2'd0, 2'd3, 16'd1, '0);
    for (int k = 1; k <= 4; k++) begin
      idle();
      check($sformatf("t6_def_k%0d", k), irq_o, {3'b000, (k == 2 || k == 3)});
    end

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      logic              we;
      logic [1:0]        ch;
      logic [1:0]        sel;
      logic [CNT_W-1:0]  wd;
      logic [NUM_CH-1:0] ack;
      we  = ($urandom_range(0, 7) == 0);
      ch  = 2'($urandom_range(0, 3));
      sel = 2'($urandom_range(0, 3));
      case (sel)
        2'd0:    wd = ($urandom_range(0, 15) == 0) ? '0 : CNT_W'($urandom_range(1, 24));
        2'd1:    wd = CNT_W'($urandom_range(0, 24));
        2'd2:    wd = CNT_W'($urandom_range(0, 12));
        default: wd = CNT_W'($urandom_range(0, 7) | (($urandom_range(0, 3) != 0) ? 1 : 0));
      endcase
      ack = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom_range(0, 15)) : '0;
      tick(we, ch, sel, wd, ack);
      check($sformatf("rnd%0d_irq", i), irq_o, m_irq_vec());
      check($sformatf("rnd%0d_ovr", i), overrun_o, m_ovr_vec());
      check($sformatf("rnd%0d_any", i), irq_any_o, |m_irq_vec());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
